pc_next_unit: RTL
=================

Name: pc_next_unit

Overview:
Next-generation program-counter block for the RV32I core. It owns the PC register and resolves the next-PC source among sequential, branch/JAL, JALR, trap vector and MRET return. It detects misaligned jump targets and illegal instructions, and holds mepc/mcause. A BOOT/RUN/HANDLER/LOCKED state machine sits between the main decoder/branch unit and instruction memory.

Parameters:
XLEN, 32, datapath and PC width (>=16)
RESET_VECTOR, 32'h0000_0000, PC value loaded by reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on any trap
IALIGN, 32, instruction alignment in bits (32 or 16); 32 enables target[1] misalignment check

Ports:
clk  in  1  core clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
stall  in  1  hold PC and state this cycle
instr_valid  in  1  current instruction is valid and retiring when not stalled
branch  in  1  conditional branch, from main_decoder
jump  in  1  JAL, from main_decoder
jalr  in  1  JALR, from main_decoder
mret  in  1  MRET, from main_decoder
illegal  in  1  illegal opcode, from main_decoder
br_flag  in  1  branch condition true, from branch_unit
imm  in  XLEN  sign-extended immediate
rs1_val  in  XLEN  rs1 operand
pc  out  XLEN  current PC to instruction memory
pc_plus4  out  XLEN  pc+4, for JAL/JALR link
pc_src  out  2  00=pc+4, 01=pc+imm, 10=jalr, 11=trap/mret
fetch_en  out  1  instruction memory read enable
flush  out  1  one-cycle redirect pulse to discard fetched instruction
trap_taken  out  1  one-cycle pulse on trap entry
mepc  out  XLEN  saved PC of trapping instruction
mcause  out  4  0=instr addr misaligned, 2=illegal instruction
locked  out  1  double-fault lockup indicator

Behaviour:
- Reset (rst=1 at edge): pc=RESET_VECTOR, state=BOOT, mepc=0, mcause=0, flush=0, trap_taken=0, locked=0. Reset overrides stall and all other inputs in every state.
- Arithmetic: all adds are modulo 2^XLEN, so wrap-around is silent. pc_plus4=pc+4. br_tgt=pc+imm. jalr_tgt=(rs1_val+imm) & ~1.
- Misaligned (IALIGN=32): the selected br_tgt/jalr_tgt has bit1=1 and the redirect is actually taken. A non-taken branch to a misaligned target is not a fault. With IALIGN=16 there is never a misalignment fault.
- Combinational select, in priority order:
  1. illegal, or misaligned-taken redirect: trap, pc_src=11.
  2. mret: pc_src=11, target=mepc.
  3. jalr: pc_src=10.
  4. jump: pc_src=01.
  5. branch&&br_flag: pc_src=01.
  6. Otherwise: pc_src=00.
- pc_src is valid only when state is RUN or HANDLER and instr_valid=1; otherwise it is 00.
- Update condition: state is RUN or HANDLER, instr_valid=1 and stall=0.
- State BOOT: fetch_en=0. Next cycle goes to RUN. pc is unchanged. BOOT lasts exactly 1 cycle after rst deasserts.
- State RUN: fetch_en=1. On the update condition, pc<=selected target.
  - Trap: mepc<=pc, mcause<=2 if illegal else 0, pc<=TRAP_VECTOR, state<=HANDLER, trap_taken=1 and flush=1 for the next cycle.
  - mret in RUN: treated as a normal redirect to mepc, state stays RUN.
  - Any non-sequential pc_src: flush=1 for one cycle after the update.
- State HANDLER: same as RUN, except:
  - mret: pc<=mepc, state<=RUN, flush=1.
  - Trap (illegal or misaligned): state<=LOCKED. mepc and mcause are NOT overwritten. pc<=TRAP_VECTOR. trap_taken is not pulsed.
- State LOCKED: locked=1, fetch_en=0, and pc, mepc and mcause are frozen. Leaves only on rst.
- Stall: pc, state, mepc and mcause hold. flush and trap_taken deassert during the stall. A redirect is evaluated on the first unstalled cycle with the inputs present then.
- flush and trap_taken are registered single-cycle pulses and never stay high for 2 consecutive cycles from one event.
- Latency: a redirect is visible on pc one cycle after the retiring edge.

Test Plan:
1. Reset with RESET_VECTOR=0; rst released; 3 valid non-branch instructions -> pc 0 (BOOT, fetch_en=0), 0, 4, 8, 0xC; pc_src=00; flush never asserted.
2. At pc=0x20, branch=1, br_flag=1, imm=0xFFFFFFF0 -> pc=0x10 next cycle, pc_src=01, flush=1 for 1 cycle. With br_flag=0 -> pc=0x24, no flush.
3. At pc=0x40, jalr=1, rs1_val=0x103, imm=0 -> pc=0x102? No: bit1 set, so this is a trap. Expect pc=0x100, mepc=0x40, mcause=0, trap_taken=1, state HANDLER. Repeat with rs1_val=0x105 -> pc=0x104, no trap.
4. illegal=1 at pc=0x80 -> pc=0x100, mepc=0x80, mcause=2. Then mret in HANDLER -> pc=0x80, state RUN, flush=1.
5. In HANDLER, illegal=1 -> locked=1, fetch_en=0, mepc still 0x80. Further inputs change nothing. rst -> pc=0, locked=0.
6. pc=0xFFFFFFFC sequential -> pc=0x0 (wrap). jump=1 with stall=1 for 2 cycles -> pc holds, then redirects on the first unstalled cycle. rst asserted during stall -> pc=RESET_VECTOR.

Source files
------------

// File: rtl/pc_next_unit.sv
// Program-counter block for the RV32I core: owns the PC, selects the next-PC source,
// raises misaligned/illegal traps, holds mepc/mcause and sequences BOOT/RUN/HANDLER/LOCKED.
module pc_next_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int              IALIGN       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            instr_valid,
    input  logic            branch,
    input  logic            jump,
    input  logic            jalr,
    input  logic            mret,
    input  logic            illegal,
    input  logic            br_flag,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [1:0]      pc_src,
    output logic            fetch_en,
    output logic            flush,
    output logic            trap_taken,
    output logic [XLEN-1:0] mepc,
    output logic [3:0]      mcause,
    output logic            locked
);

    typedef enum logic [1:0] {
        ST_BOOT    = 2'b00,
        ST_RUN     = 2'b01,
        ST_HANDLER = 2'b10,
        ST_LOCKED  = 2'b11
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP     = XLEN'(32'd4);
    localparam logic [XLEN-1:0] CLEAR_BIT0  = ~(XLEN'(32'd1));
    localparam logic            CHECK_ALIGN = (IALIGN == 32);

    state_t          state_r;
    state_t          state_n_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] mepc_r;
    logic [3:0]      mcause_r;
    logic            flush_r;
    logic            trap_taken_r;

    logic [XLEN-1:0] br_tgt_s;
    logic [XLEN-1:0] jalr_tgt_s;
    logic [XLEN-1:0] sel_tgt_s;
    logic [XLEN-1:0] next_pc_s;
    logic [1:0]      pc_src_s;
    logic            active_s;
    logic            redirect_s;
    logic            trap_s;
    logic            update_s;

    // Target arithmetic and prioritised next-PC source selection.
    always_comb begin
        br_tgt_s   = pc_r + imm;
        jalr_tgt_s = (rs1_val + imm) & CLEAR_BIT0;
        sel_tgt_s  = jalr ? jalr_tgt_s : br_tgt_s;
        redirect_s = jalr | jump | (branch & br_flag);
        active_s   = ((state_r == ST_RUN) || (state_r == ST_HANDLER)) && instr_valid;
        // Only a redirect that is actually taken can fault on a misaligned target.
        trap_s     = illegal | (CHECK_ALIGN & redirect_s & sel_tgt_s[1]);
        update_s   = active_s & ~stall;
        pc_src_s   = 2'b00;
        next_pc_s  = pc_r + PC_STEP;
        if (!active_s) begin
            pc_src_s  = 2'b00;
        end else if (trap_s) begin
            pc_src_s  = 2'b11;
            next_pc_s = TRAP_VECTOR;
        end else if (mret) begin
            pc_src_s  = 2'b11;
            next_pc_s = mepc_r;
        end else if (jalr) begin
            pc_src_s  = 2'b10;
            next_pc_s = jalr_tgt_s;
        end else if (jump || (branch && br_flag)) begin
            pc_src_s  = 2'b01;
            next_pc_s = br_tgt_s;
        end else begin
            pc_src_s  = 2'b00;
        end
    end

    // Next-state logic for the boot/run/handler/lockup sequencer.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_BOOT: begin
                state_n_s = ST_RUN;
            end
            ST_RUN: begin
                if (update_s && trap_s) begin
                    state_n_s = ST_HANDLER;
                end else begin
                    state_n_s = ST_RUN;
                end
            end
            ST_HANDLER: begin
                if (update_s && trap_s) begin
                    state_n_s = ST_LOCKED;
                end else if (update_s && mret) begin
                    state_n_s = ST_RUN;
                end else begin
                    state_n_s = ST_HANDLER;
                end
            end
            ST_LOCKED: begin
                state_n_s = ST_LOCKED;
            end
            default: begin
                state_n_s = ST_BOOT;
            end
        endcase
    end

    // PC, trap CSRs, state and redirect pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_BOOT;
            pc_r         <= RESET_VECTOR;
            mepc_r       <= '0;
            mcause_r     <= 4'd0;
            flush_r      <= 1'b0;
            trap_taken_r <= 1'b0;
        end else begin
            state_r      <= state_n_s;
            flush_r      <= update_s && (pc_src_s != 2'b00);
            trap_taken_r <= update_s && trap_s && (state_r == ST_RUN);
            if (update_s) begin
                pc_r <= next_pc_s;
            end
            // A second fault inside the handler must not clobber the first trap's context.
            if (update_s && trap_s && (state_r == ST_RUN)) begin
                mepc_r   <= pc_r;
                mcause_r <= illegal ? 4'd2 : 4'd0;
            end
        end
    end

    assign pc         = pc_r;
    assign pc_plus4   = pc_r + PC_STEP;
    assign pc_src     = pc_src_s;
    assign fetch_en   = (state_r == ST_RUN) || (state_r == ST_HANDLER);
    assign flush      = flush_r;
    assign trap_taken = trap_taken_r;
    assign mepc       = mepc_r;
    assign mcause     = mcause_r;
    assign locked     = (state_r == ST_LOCKED);

endmodule
